cadre_anime: RTL and testbench

CADRE_ANIME -- requirements
Module: cadre_anime

---
 rtl/cadre_pkg.sv | 23 ++
 rtl/cadre_zone.sv | 42 ++++
 rtl/cadre_anime.sv | 118 +++++++++++
 tb/tb_cadre_anime.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cadre_pkg.sv
// Shared constants for the animated frame: 3-level RGB colour encoding,
// default VGA visible-area offsets and the flash FSM state type.
package cadre_pkg;

  // Colour index packs three 0..2 levels as r*9 + g*3 + b.
  function automatic logic [4:0] rgb(input int r, input int g, input int b);
    return 5'(r * 9 + g * 3 + b);
  endfunction

  localparam logic [4:0] C_NOIR  = rgb(0, 0, 0);
  localparam logic [4:0] C_JAUNE = rgb(2, 2, 0);
  localparam logic [4:0] C_BLANC = rgb(2, 2, 2);

  localparam int H_DEBUT_VGA = 96 + 16;
  localparam int V_DEBUT_VGA = 2 + 10;

  typedef enum logic [1:0] {
    REPOS  = 2'd0,
    ALLUME = 2'd1,
    ETEINT = 2'd2
  } etat_t;

endpackage

// File: rtl/cadre_zone.sv
// Combinational geometry: is the current pixel inside the visible frame,
// and does it belong to the border band of width EPAISSEUR.
module cadre_zone #(
  parameter int H_DEBUT   = 112,
  parameter int V_DEBUT   = 12,
  parameter int H_LARGEUR = 640,
  parameter int V_HAUTEUR = 480,
  parameter int EPAISSEUR = 3
) (
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  output logic        dans_cadre,
  output logic        bordure
);

  localparam int MIN_DIM = (H_LARGEUR < V_HAUTEUR) ? H_LARGEUR : V_HAUTEUR;

  if (EPAISSEUR < 1 || 2 * EPAISSEUR > MIN_DIM) begin : g_bad_epaisseur
    $error("cadre_zone: EPAISSEUR must be >= 1 and fit twice in the frame");
  end

  // Bounds are widened to 12 bits so H_DEBUT+H_LARGEUR cannot wrap.
  localparam logic [11:0] H_MIN = 12'(H_DEBUT);
  localparam logic [11:0] H_MAX = 12'(H_DEBUT + H_LARGEUR);
  localparam logic [11:0] H_BG  = 12'(H_DEBUT + EPAISSEUR);
  localparam logic [11:0] H_BD  = 12'(H_DEBUT + H_LARGEUR - EPAISSEUR);
  localparam logic [11:0] V_MIN = 12'(V_DEBUT);
  localparam logic [11:0] V_MAX = 12'(V_DEBUT + V_HAUTEUR);
  localparam logic [11:0] V_BH  = 12'(V_DEBUT + EPAISSEUR);
  localparam logic [11:0] V_BB  = 12'(V_DEBUT + V_HAUTEUR - EPAISSEUR);

  logic [11:0] h;
  logic [11:0] v;

  assign h = {1'b0, hpos};
  assign v = {1'b0, vpos};

  assign dans_cadre = (h >= H_MIN) && (h < H_MAX) && (v >= V_MIN) && (v < V_MAX);
  assign bordure    = dans_cadre &&
                      ((h < H_BG) || (h >= H_BD) || (v < V_BH) || (v >= V_BB));

endmodule

// File: rtl/cadre_anime.sv
// Registered border colour generator with a frame-counted flash animation
// triggered by a one-cycle flash request.
module cadre_anime
  import cadre_pkg::*;
#(
  parameter int          H_DEBUT      = H_DEBUT_VGA,
  parameter int          V_DEBUT      = V_DEBUT_VGA,
  parameter int          H_LARGEUR    = 640,
  parameter int          V_HAUTEUR    = 480,
  parameter int          EPAISSEUR    = 3,
  parameter logic [4:0]  C_CADRE      = C_JAUNE,
  parameter logic [4:0]  C_FLASH      = C_BLANC,
  parameter logic [4:0]  C_FOND       = C_NOIR,
  parameter int          NB_FLASH     = 4,
  parameter int          DEMI_PERIODE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        flash,
  output logic [4:0]  couleur,
  output logic        occupe
);

  localparam int PW = (DEMI_PERIODE > 1) ? $clog2(DEMI_PERIODE) : 1;
  localparam int FW = (NB_FLASH > 1) ? $clog2(NB_FLASH) : 1;
  localparam logic [PW-1:0] PH_MAX = PW'(DEMI_PERIODE - 1);
  localparam logic [FW-1:0] NF_MAX = FW'(NB_FLASH - 1);

  logic          dans_cadre;
  logic          bordure;
  logic          zero;
  logic          tick;
  logic          zero_q;
  etat_t         state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] nflash_q, nflash_d;
  logic [4:0]    couleur_q, couleur_d;
  logic          occupe_q;

  cadre_zone #(
    .H_DEBUT   (H_DEBUT),
    .V_DEBUT   (V_DEBUT),
    .H_LARGEUR (H_LARGEUR),
    .V_HAUTEUR (V_HAUTEUR),
    .EPAISSEUR (EPAISSEUR)
  ) u_zone (
    .hpos       (hpos),
    .vpos       (vpos),
    .dans_cadre (dans_cadre),
    .bordure    (bordure)
  );

  // Frame tick fires only on the first cycle of the (0,0) position.
  assign zero = (hpos == 11'd0) && (vpos == 11'd0);
  assign tick = zero && !zero_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    nflash_d = nflash_q;
    if (flash) begin
      state_d  = ALLUME;
      phase_d  = '0;
      nflash_d = '0;
    end else if (tick && state_q != REPOS) begin
      if (phase_q == PH_MAX) begin
        phase_d = '0;
        if (state_q == ALLUME) begin
          state_d = ETEINT;
        end else if (nflash_q == NF_MAX) begin
          state_d  = REPOS;
          nflash_d = '0;
        end else begin
          state_d  = ALLUME;
          nflash_d = nflash_q + 1'b1;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    couleur_d = C_FOND;
    if (dans_cadre && bordure) begin
      unique case (state_q)
        REPOS:   couleur_d = C_CADRE;
        ALLUME:  couleur_d = C_FLASH;
        default: couleur_d = C_FOND;
      endcase
    end
  end

  // occupe is loaded from the next state so it always matches state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REPOS;
      phase_q   <= '0;
      nflash_q  <= '0;
      zero_q    <= 1'b0;
      couleur_q <= C_FOND;
      occupe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      nflash_q  <= nflash_d;
      zero_q    <= zero;
      couleur_q <= couleur_d;
      occupe_q  <= (state_d != REPOS);
    end
  end

  assign couleur = couleur_q;
  assign occupe  = occupe_q;

endmodule

// File: tb/tb_cadre_anime.sv
// Self-checking bench for cadre_anime: geometry table, flash sequences,
// restart/collision/reset corner cases and randomized traffic vs a model.
module tb_cadre_anime;

  localparam int DP    = 8;
  localparam int NB    = 4;
  localparam int TOTAL = 2 * NB * DP;

  logic        clk;
  logic        reset;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        flash;
  logic [4:0]  couleur;
  logic        occupe;
  logic [4:0]  couleur5;
  logic        occupe5;

  int total = 0;
  int bad   = 0;

  // Reference model: ticks elapsed since the last flash request.
  bit mActive;
  int mT;
  bit mPrevZero;
  int expCol;
  int expOcc;

  typedef struct {
    int h;
    int v;
    int exp3;
    int exp5;
  } geomVec_t;

  cadre_anime dut (
    .clk     (clk),
    .reset   (reset),
    .hpos    (hpos),
    .vpos    (vpos),
    .flash   (flash),
    .couleur (couleur),
    .occupe  (occupe)
  );

  cadre_anime #(.EPAISSEUR(5)) dut5 (
    .clk     (clk),
    .reset   (reset),
    .hpos    (hpos),
    .vpos    (vpos),
    .flash   (flash),
    .couleur (couleur5),
    .occupe  (occupe5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isBorder(input int h, input int v);
    bit inFrame;
    bit edgeBand;
    inFrame  = (h >= 112) && (h < 112 + 640) && (v >= 12) && (v < 12 + 480);
    edgeBand = (h < 112 + 3) || (h >= 112 + 640 - 3) || (v < 12 + 3) || (v >= 12 + 480 - 3);
    return inFrame && edgeBand;
  endfunction

  function automatic int borderColour(input bit active, input int t);
    if (!active) return 24;
    return ((t / DP) % 2 == 0) ? 26 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelEdge(input int h, input int v, input bit f, input bit r);
    bit z;
    bit tk;
    expCol = r ? 0 : (isBorder(h, v) ? borderColour(mActive, mT) : 0);
    z  = (h == 0) && (v == 0);
    tk = z && !mPrevZero;
    mPrevZero = r ? 1'b0 : z;
    if (r) begin
      mActive = 1'b0;
      mT = 0;
    end else if (f) begin
      mActive = 1'b1;
      mT = 0;
    end else if (tk && mActive) begin
      mT++;
      if (mT == TOTAL) mActive = 1'b0;
    end
    expOcc = mActive ? 1 : 0;
  endtask

  task automatic applyStimulus(input int h, input int v, input bit f, input bit r);
    hpos  = 11'(h);
    vpos  = 11'(v);
    flash = f;
    reset = r;
    @(posedge clk);
    #1;
    modelEdge(h, v, f, r);
    checkOutput("model_couleur", {27'd0, couleur}, expCol);
    checkOutput("model_occupe", {31'd0, occupe}, expOcc);
  endtask

  task automatic tickOnce();
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(112, 12, 1'b0, 1'b0);
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tickOnce();
  endtask

  initial begin
    geomVec_t geomTab[14];
    int hList[12];
    int vList[10];
    int h;
    int v;

    geomTab = '{
      '{114, 212, 24, 24}, '{115, 212,  0, 24},
      '{751, 212, 24, 24}, '{752, 212,  0,  0},
      '{751, 491, 24, 24}, '{751, 492,  0,  0},
      '{412,  14, 24, 24}, '{412,  15,  0, 24},
      '{116, 212,  0, 24}, '{117, 212,  0,  0},
      '{412,  16,  0, 24}, '{412,  17,  0,  0},
      '{747, 212,  0, 24}, '{111, 212,  0,  0}
    };
    hList = '{0, 111, 112, 113, 114, 115, 300, 748, 749, 751, 752, 1000};
    vList = '{0, 11, 12, 14, 15, 200, 488, 489, 491, 492};

    mActive = 1'b0; mT = 0; mPrevZero = 1'b0;
    hpos = '0; vpos = '0; flash = 1'b0; reset = 1'b1;

    // Reset state
    applyStimulus(112, 12, 1'b0, 1'b1);
    checkOutput("reset_couleur", {27'd0, couleur}, 0);
    checkOutput("reset_occupe", {31'd0, occupe}, 0);
    applyStimulus(112, 12, 1'b0, 1'b0);

    // Geometry, default and EPAISSEUR=5 instances
    for (int i = 0; i < 14; i++) begin
      applyStimulus(geomTab[i].h, geomTab[i].v, 1'b0, 1'b0);
      checkOutput($sformatf("geom_%0d_%0d", geomTab[i].h, geomTab[i].v),
                  {27'd0, couleur}, geomTab[i].exp3);
      checkOutput($sformatf("geom5_%0d_%0d", geomTab[i].h, geomTab[i].v),
                  {27'd0, couleur5}, geomTab[i].exp5);
    end

    // Basic flash sequence
    applyStimulus(112, 12, 1'b1, 1'b0);
    checkOutput("flash_occupe", {31'd0, occupe}, 1);
    applyStimulus(112, 12, 1'b0, 1'b0);
    checkOutput("flash_on", {27'd0, couleur}, 26);
    tickN(7);
    checkOutput("flash_on7", {27'd0, couleur}, 26);
    tickN(1);
    checkOutput("flash_off8", {27'd0, couleur}, 0);
    tickN(8);
    checkOutput("flash_on16", {27'd0, couleur}, 26);
    tickN(TOTAL - 17);
    checkOutput("flash_busy63", {31'd0, occupe}, 1);
    tickN(1);
    checkOutput("flash_end_couleur", {27'd0, couleur}, 24);
    checkOutput("flash_end_occupe", {31'd0, occupe}, 0);

    // Restart during ETEINT
    applyStimulus(112, 12, 1'b1, 1'b0);
    tickN(12);
    checkOutput("restart_eteint", {27'd0, couleur}, 0);
    applyStimulus(112, 12, 1'b1, 1'b0);
    applyStimulus(112, 12, 1'b0, 1'b0);
    checkOutput("restart_allume", {27'd0, couleur}, 26);
    tickN(TOTAL - 1);
    checkOutput("restart_busy63", {31'd0, occupe}, 1);
    tickN(1);
    checkOutput("restart_done", {31'd0, occupe}, 0);

    // Flash coincident with a tick, then reset mid-sequence
    applyStimulus(0, 0, 1'b1, 1'b0);
    applyStimulus(112, 12, 1'b0, 1'b0);
    tickN(7);
    checkOutput("collide_on7", {27'd0, couleur}, 26);
    tickN(1);
    checkOutput("collide_off8", {27'd0, couleur}, 0);
    tickN(12);
    checkOutput("collide_busy20", {31'd0, occupe}, 1);
    applyStimulus(112, 12, 1'b0, 1'b1);
    checkOutput("abort_occupe", {31'd0, occupe}, 0);
    applyStimulus(112, 12, 1'b0, 1'b0);
    checkOutput("abort_couleur", {27'd0, couleur}, 24);

    // Flash together with reset is ignored
    applyStimulus(112, 12, 1'b1, 1'b1);
    applyStimulus(112, 12, 1'b0, 1'b0);
    checkOutput("flashreset_occupe", {31'd0, occupe}, 0);
    checkOutput("flashreset_couleur", {27'd0, couleur}, 24);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        h = 0;
        v = 0;
      end else begin
        h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : hList[$urandom_range(0, 11)];
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : vList[$urandom_range(0, 9)];
      end
      applyStimulus(h, v, ($urandom_range(0, 299) == 0), ($urandom_range(0, 999) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
